// File: rtl/mor1kx_pic_arb_pkg.sv
// Shared definitions for the PIC interrupt arbiter: line geometry and FSM state encodings.
package mor1kx_pic_arb_pkg;

    localparam int NUM_LINES = 32;
    localparam int LINE_W    = 5;

    localparam logic [1:0] PIC_ST_IDLE     = 2'd0;
    localparam logic [1:0] PIC_ST_REQ      = 2'd1;
    localparam logic [1:0] PIC_ST_WAIT_IEE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = PIC_ST_IDLE,
        ST_REQ      = PIC_ST_REQ,
        ST_WAIT_IEE = PIC_ST_WAIT_IEE
    } pic_state_t;

endpackage

// File: rtl/mor1kx_pic_arb_if.sv
// Bundle between the PIC status register / control unit and the interrupt arbiter.
interface mor1kx_pic_arb_if #(
    parameter int CNT_WIDTH = 16
);
    import mor1kx_pic_arb_pkg::*;

    logic [NUM_LINES-1:0] picsr_i;
    logic                 iee_i;
    logic                 irq_ack_i;
    logic                 irq_req_o;
    logic [LINE_W-1:0]    irq_line_o;
    logic [LINE_W-1:0]    irq_taken_line_o;
    logic [CNT_WIDTH-1:0] irq_cnt_o;

    modport slave (
        input  picsr_i, iee_i, irq_ack_i,
        output irq_req_o, irq_line_o, irq_taken_line_o, irq_cnt_o
    );

    modport master (
        output picsr_i, iee_i, irq_ack_i,
        input  irq_req_o, irq_line_o, irq_taken_line_o, irq_cnt_o
    );

endinterface

// File: rtl/mor1kx_pic_arb_prio_enc.sv
// Wrap-around priority encoder: first set request at or above i_start, wrapping 31 -> 0.
module mor1kx_pic_prio_enc
    import mor1kx_pic_arb_pkg::*;
(
    input  logic [NUM_LINES-1:0] i_req,
    input  logic [LINE_W-1:0]    i_start,
    output logic [LINE_W-1:0]    o_index,
    output logic                 o_found
);

    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!o_found && i_req[i_start + LINE_W'(i)]) begin
                o_index = i_start + LINE_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mor1kx_pic_arb.sv
// PIC interrupt arbiter: picks one pending line, holds the request until taken or withdrawn.
module mor1kx_pic_arb
    import mor1kx_pic_arb_pkg::*;
#(
    parameter     OPTION_PIC_ARB       = "FIXED",
    parameter int OPTION_PIC_CNT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    mor1kx_pic_arb_if.slave pic
);

    localparam bit RoundRobin = (OPTION_PIC_ARB == "ROUND_ROBIN");

    pic_state_t                      r_state;
    pic_state_t                      w_state_nxt;
    logic [LINE_W-1:0]               r_line;
    logic [LINE_W-1:0]               w_line_nxt;
    logic [LINE_W-1:0]               r_taken;
    logic [LINE_W-1:0]               w_taken_nxt;
    logic [OPTION_PIC_CNT_WIDTH-1:0] r_cnt;
    logic [OPTION_PIC_CNT_WIDTH-1:0] w_cnt_nxt;
    logic [LINE_W-1:0]               r_ptr;
    logic [LINE_W-1:0]               w_ptr_nxt;
    logic [LINE_W-1:0]               w_start;
    logic [LINE_W-1:0]               w_win;
    logic                            w_found;

    // Fixed priority is simply the round-robin search anchored at line 0.
    assign w_start = RoundRobin ? r_ptr : '0;

    mor1kx_pic_prio_enc u_prio_enc (
        .i_req   (pic.picsr_i),
        .i_start (w_start),
        .o_index (w_win),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_line  <= '0;
            r_taken <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_taken <= w_taken_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_taken_nxt = r_taken;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (pic.iee_i && w_found) begin
                    w_line_nxt  = w_win;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Acknowledge beats a simultaneous withdraw: the exception is already taken.
                if (pic.irq_ack_i) begin
                    w_state_nxt = ST_WAIT_IEE;
                    w_taken_nxt = r_line;
                    w_cnt_nxt   = r_cnt + OPTION_PIC_CNT_WIDTH'(1);
                    w_ptr_nxt   = r_line + LINE_W'(1);
                end else if (!pic.iee_i || !pic.picsr_i[r_line]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_IEE: begin
                if (pic.iee_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pic.irq_req_o        = (r_state == ST_REQ);
    assign pic.irq_line_o       = r_line;
    assign pic.irq_taken_line_o = r_taken;
    assign pic.irq_cnt_o        = r_cnt;

endmodule

// File: tb/tb_mor1kx_pic_arb.sv
// Runs a FIXED/16-bit and a ROUND_ROBIN/4-bit arbiter side by side against a behavioural model.
module tb_mor1kx_pic_arb;

    logic        clk;
    logic        rst;
    logic [31:0] picsr;
    logic        iee;
    logic        ack;

    int nCompared   = 0;
    int nMismatched = 0;

    mor1kx_pic_arb_if #(.CNT_WIDTH(16)) busFix ();
    mor1kx_pic_arb_if #(.CNT_WIDTH(4))  busRr ();

    assign busFix.picsr_i   = picsr;
    assign busFix.iee_i     = iee;
    assign busFix.irq_ack_i = ack;
    assign busRr.picsr_i    = picsr;
    assign busRr.iee_i      = iee;
    assign busRr.irq_ack_i  = ack;

    mor1kx_pic_arb #(.OPTION_PIC_ARB("FIXED"), .OPTION_PIC_CNT_WIDTH(16)) u_fix (
        .clk (clk),
        .rst (rst),
        .pic (busFix)
    );

    mor1kx_pic_arb #(.OPTION_PIC_ARB("ROUND_ROBIN"), .OPTION_PIC_CNT_WIDTH(4)) u_rr (
        .clk (clk),
        .rst (rst),
        .pic (busRr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model index 0 = fixed/16-bit counter, 1 = round-robin/4-bit counter.
    bit requesting[2];
    bit waitingIee[2];
    int mLine[2];
    int mTaken[2];
    int mCnt[2];
    int mPtr[2];
    int cntMod[2] = '{65536, 16};

    function automatic int pickLine(logic [31:0] p, int start);
        for (int k = 0; k < 32; k++) begin
            if (p[(start + k) % 32]) return (start + k) % 32;
        end
        return 0;
    endfunction

    task automatic modelStep(int m);
        if (rst) begin
            requesting[m] = 0;
            waitingIee[m] = 0;
            mLine[m] = 0;
            mTaken[m] = 0;
            mCnt[m] = 0;
            mPtr[m] = 0;
        end else if (requesting[m]) begin
            if (ack) begin
                mTaken[m] = mLine[m];
                mCnt[m] = (mCnt[m] + 1) % cntMod[m];
                mPtr[m] = (mLine[m] + 1) % 32;
                requesting[m] = 0;
                waitingIee[m] = 1;
            end else if (!iee || !picsr[mLine[m]]) begin
                requesting[m] = 0;
            end
        end else if (waitingIee[m]) begin
            if (iee) waitingIee[m] = 0;
        end else if (iee && picsr != 32'd0) begin
            mLine[m] = pickLine(picsr, (m == 1) ? mPtr[m] : 0);
            requesting[m] = 1;
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) modelStep(m);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("fix_req",   int'(busFix.irq_req_o),        int'(requesting[0]));
        checkOutput("fix_line",  int'(busFix.irq_line_o),       mLine[0]);
        checkOutput("fix_taken", int'(busFix.irq_taken_line_o), mTaken[0]);
        checkOutput("fix_cnt",   int'(busFix.irq_cnt_o),        mCnt[0]);
        checkOutput("rr_req",    int'(busRr.irq_req_o),         int'(requesting[1]));
        checkOutput("rr_line",   int'(busRr.irq_line_o),        mLine[1]);
        checkOutput("rr_taken",  int'(busRr.irq_taken_line_o),  mTaken[1]);
        checkOutput("rr_cnt",    int'(busRr.irq_cnt_o),         mCnt[1]);
    end

    // Drive inputs at a falling edge and return at the next falling edge, after the rising edge used them.
    task automatic applyStimulus(input logic [31:0] p, input logic ie, input logic a);
        picsr = p;
        iee   = ie;
        ack   = a;
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(32'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    int rrExp[4] = '{0, 3, 31, 0};
    int cntBefore;

    initial begin
        rst   = 1'b1;
        picsr = 32'd0;
        iee   = 1'b0;
        ack   = 1'b0;
        @(negedge clk);
        applyStimulus(32'd0, 1'b0, 1'b0);
        checkOutput("reset_req",   int'(busFix.irq_req_o), 0);
        checkOutput("reset_line",  int'(busRr.irq_line_o), 0);
        checkOutput("reset_cnt",   int'(busFix.irq_cnt_o), 0);
        rst = 1'b0;

        // Lowest set bit of 0x28 is line 3, visible one cycle after the request condition.
        applyStimulus(32'h0000_0028, 1'b1, 1'b0);
        checkOutput("fixed_req_3",   int'(busFix.irq_req_o), 1);
        checkOutput("fixed_line_3",  int'(busFix.irq_line_o), 3);
        checkOutput("model_line_3",  mLine[0], 3);
        applyStimulus(32'h0000_0028, 1'b1, 1'b1);
        checkOutput("fixed_taken_3", int'(busFix.irq_taken_line_o), 3);
        checkOutput("fixed_cnt_1",   int'(busFix.irq_cnt_o), 1);
        applyStimulus(32'd0, 1'b1, 1'b0);
        applyStimulus(32'd0, 1'b1, 1'b0);

        // Round robin from pointer 0 over lines {0,3,31}.
        applyReset();
        for (int r = 0; r < 4; r++) begin
            applyStimulus(32'h8000_0009, 1'b1, 1'b0);
            checkOutput("rr_round_req",  int'(busRr.irq_req_o), 1);
            checkOutput("rr_round_line", int'(busRr.irq_line_o), rrExp[r]);
            checkOutput("fix_round_line", int'(busFix.irq_line_o), 0);
            applyStimulus(32'h8000_0009, 1'b1, 1'b1);
            applyStimulus(32'd0, 1'b0, 1'b0);
            applyStimulus(32'd0, 1'b1, 1'b0);
        end
        checkOutput("rr_cnt_4", int'(busRr.irq_cnt_o), 4);

        // Withdraw: line 5 request dropped without acknowledge.
        applyStimulus(32'h0000_0020, 1'b1, 1'b0);
        checkOutput("wd_line_5", int'(busFix.irq_line_o), 5);
        applyStimulus(32'd0, 1'b1, 1'b0);
        checkOutput("wd_req_0",   int'(busFix.irq_req_o), 0);
        checkOutput("wd_cnt",     int'(busFix.irq_cnt_o), 4);
        checkOutput("wd_line_hold", int'(busFix.irq_line_o), 5);

        // Ack coinciding with iee=0 still counts; then level re-request after WAIT_IEE.
        applyStimulus(32'h0000_0020, 1'b1, 1'b0);
        applyStimulus(32'h0000_0020, 1'b0, 1'b1);
        checkOutput("ackwd_cnt",   int'(busFix.irq_cnt_o), 5);
        checkOutput("ackwd_taken", int'(busFix.irq_taken_line_o), 5);
        applyStimulus(32'h0000_0020, 1'b0, 1'b0);
        checkOutput("wait_req_0", int'(busFix.irq_req_o), 0);
        applyStimulus(32'h0000_0020, 1'b1, 1'b0);
        applyStimulus(32'h0000_0020, 1'b1, 1'b0);
        checkOutput("rereq_req",  int'(busRr.irq_req_o), 1);
        checkOutput("rereq_line", int'(busRr.irq_line_o), 5);
        applyStimulus(32'd0, 1'b0, 1'b0);

        // Counter wrap on the 4-bit instance, then a stray acknowledge.
        applyReset();
        for (int n = 1; n <= 16; n++) begin
            applyStimulus(32'h0000_0001, 1'b1, 1'b0);
            applyStimulus(32'h0000_0001, 1'b1, 1'b1);
            applyStimulus(32'd0, 1'b1, 1'b0);
            if (n == 15) checkOutput("rr_cnt_15", int'(busRr.irq_cnt_o), 15);
        end
        checkOutput("rr_cnt_wrap", int'(busRr.irq_cnt_o), 0);
        checkOutput("fix_cnt_16",  int'(busFix.irq_cnt_o), 16);
        cntBefore = int'(busFix.irq_cnt_o);
        applyStimulus(32'd0, 1'b0, 1'b1);
        checkOutput("stray_ack_cnt", int'(busFix.irq_cnt_o), 16);
        checkOutput("stray_ack_req", int'(busFix.irq_req_o), 0);

        // Reset beats a coincident acknowledge.
        applyStimulus(32'h0000_0004, 1'b1, 1'b0);
        checkOutput("pre_rst_line", int'(busFix.irq_line_o), 2);
        rst = 1'b1;
        applyStimulus(32'h0000_0004, 1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("rst_ack_req",   int'(busFix.irq_req_o), 0);
        checkOutput("rst_ack_line",  int'(busFix.irq_line_o), 0);
        checkOutput("rst_ack_taken", int'(busFix.irq_taken_line_o), 0);
        checkOutput("rst_ack_cnt",   int'(busFix.irq_cnt_o), 0);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus($urandom() & $urandom() & $urandom(),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
